sort_array_ctrl: RTL

//  Sequences a linear chain of N sort cells (keep-min, pass-larger) as one batch sorter.
//  - Accepts a batch of W-bit values over a valid/ready input stream and pushes each value into the chain.
//  - Shifts the chain out in descending order over a valid/ready output stream.
//  - Owns the cell enable, clear and shift controls; the cells themselves hold no control logic.

---
 rtl/sort_array_ctrl.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/sort_array_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : sort_array_ctrl
// Purpose : Control sequencer for an external linear chain of N sort cells
//           (each cell keeps the smaller value and passes the larger one on).
//           It loads a batch of values into the chain, then shifts the chain
//           out so that the values leave in descending order.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   W : data width of each value and each cell
//   N : number of cells in the chain and maximum batch length (N >= 2)
// Ports
//   clk, rst_n         : clock (rising edge), synchronous active-low reset
//   in_valid/in_ready  : input stream handshake; in_data, in_last carry the beat
//   out_valid/out_ready: output stream handshake; out_data, out_last carry the
//                        beat (largest value first)
//   cell_en            : chain advances this cycle
//   cell_clr           : all cells load the all-ones empty sentinel
//   cell_shift         : 1 = plain shift toward the tail, 0 = compare/insert
//   cell_din           : value entering cell 0
//   cell_tail          : stored value of cell N-1
//   err_trunc          : 1-cycle pulse when a batch is cut at N beats
//   batch_cnt          : completed-batch counter
// Configuration
//   SORT_CTRL_STATS_EN : when defined, batch_cnt counts out_last handshakes
//                        (wrapping at 16 bits); otherwise it is tied to 0.
// ============================================================================
module sort_array_ctrl #(
  parameter int W = 8,
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic         cell_en,
  output logic         cell_clr,
  output logic         cell_shift,
  output logic [W-1:0] cell_din,
  input  logic [W-1:0] cell_tail,
  output logic         err_trunc,
  output logic [15:0]  batch_cnt
);

  localparam int            CW     = $clog2(N + 1);
  localparam logic [CW-1:0] C_N    = CW'(N);
  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [W-1:0]  C_SENT = {W{1'b1}};

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_LOAD  = 2'd1,
    S_SKIP  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] skip_q;

  logic [CW-1:0] cnt_inc;
  logic          in_fire;
  logic          out_fire;
  logic          batch_end;

  assign in_fire   = (state_q == S_LOAD) && in_valid;
  assign out_fire  = (state_q == S_DRAIN) && out_ready;
  assign cnt_inc   = cnt_q + C_ONE;
  // A batch ends on an explicit last beat or when the chain is full.
  assign batch_end = in_fire && (in_last || (cnt_inc == C_N));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_CLEAR;
      cnt_q   <= '0;
      skip_q  <= '0;
    end else begin
      case (state_q)
        S_CLEAR: begin
          cnt_q   <= '0;
          state_q <= S_LOAD;
        end
        S_LOAD: begin
          if (in_fire) begin
            cnt_q <= cnt_inc;
            if (batch_end) begin
              // Sentinels parked at the tail must be shifted away before the
              // largest real value reaches cell_tail.
              skip_q  <= C_N - cnt_inc;
              state_q <= (cnt_inc == C_N) ? S_DRAIN : S_SKIP;
            end
          end
        end
        S_SKIP: begin
          skip_q <= skip_q - C_ONE;
          if (skip_q == C_ONE) begin
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (out_ready) begin
            cnt_q <= cnt_q - C_ONE;
            if (cnt_q == C_ONE) begin
              state_q <= S_CLEAR;
            end
          end
        end
        default: state_q <= S_CLEAR;
      endcase
    end
  end

  // Control outputs decode the state register; only cell_en, cell_din and
  // err_trunc are gated by the live handshake inputs.
  always_comb begin
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    cell_en    = 1'b0;
    cell_clr   = 1'b0;
    cell_shift = 1'b0;
    cell_din   = C_SENT;
    case (state_q)
      S_CLEAR: begin
        cell_clr = 1'b1;
      end
      S_LOAD: begin
        in_ready = 1'b1;
        cell_din = in_data;
        cell_en  = in_valid;
      end
      S_SKIP: begin
        cell_en    = 1'b1;
        cell_shift = 1'b1;
      end
      S_DRAIN: begin
        out_valid  = 1'b1;
        out_last   = (cnt_q == C_ONE);
        cell_shift = 1'b1;
        cell_en    = out_ready;
      end
      default: begin
        cell_clr = 1'b1;
      end
    endcase
  end

  // The tail is stable while the chain is not enabled, so out_data holds
  // automatically during output back-pressure.
  assign out_data  = cell_tail;
  assign err_trunc = in_fire && !in_last && (cnt_inc == C_N);

`ifdef SORT_CTRL_STATS_EN
  logic [15:0] batch_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      batch_cnt_q <= 16'h0000;
    end else if (out_fire && out_last) begin
      batch_cnt_q <= batch_cnt_q + 16'd1;
    end
  end

  assign batch_cnt = batch_cnt_q;
`else
  assign batch_cnt = 16'h0000;
`endif

endmodule
`default_nettype wire
